// File: rtl/icache_fetch_group_pkg.sv
// Shared types and default widths for the fetch-group instruction cache and the fetch unit.
// Optional macro ICACHE_PERF_CNT_EN (used by the top) does not affect this package.
package icache_fetch_group_pkg;

  localparam int ADDR_W_DEF     = 15;
  localparam int DATA_W_DEF     = 16;
  localparam int FETCH_W_DEF    = 4;
  localparam int LINE_WORDS_DEF = 8;
  localparam int NUM_LINES_DEF  = 64;

  localparam int OFF_W = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W = $clog2(NUM_LINES_DEF);
  localparam int TAG_W = ADDR_W_DEF - OFF_W - IDX_W;
  localparam int CNT_W = $clog2(FETCH_W_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Lanes left before the line boundary, capped at the group width.
  function automatic int group_lanes(input int fetch_w, input int line_words, input int off);
    return (line_words - off < fetch_w) ? (line_words - off) : fetch_w;
  endfunction

endpackage

// File: rtl/icache_fetch_group_data_array.sv
// Line-wide instruction data RAM: one word written per cycle, whole line read synchronously.
// Optional macro ICACHE_PERF_CNT_EN does not affect this block.
module icache_data_array
  import icache_fetch_group_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int OFF_BITS   = OFF_W,
  parameter int IDX_BITS   = IDX_W
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [IDX_BITS-1:0]          wr_idx,
  input  logic [OFF_BITS-1:0]          wr_off,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [IDX_BITS-1:0]          rd_idx,
  output logic [LINE_WORDS*DATA_W-1:0] rd_line
);

  logic [LINE_WORDS*DATA_W-1:0] mem [NUM_LINES];

  // Word w of a line lives at bits [w*DATA_W +: DATA_W].
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx][int'(wr_off)*DATA_W +: DATA_W] <= wr_data;
    rd_line <= mem[rd_idx];
  end

endmodule

// File: rtl/icache_fetch_group.sv
// Direct-mapped instruction cache returning up to FETCH_W consecutive instructions per request.
// Define ICACHE_PERF_CNT_EN to add saturating 32-bit hit_count/miss_count outputs.
//
// state  | meaning
// IDLE   | ready for a request
// LOOKUP | tag compare on the latched address
// FILL   | burst-read the line from backing memory
// RESP   | read the line and return the fetch group
module icache_fetch_group
  import icache_fetch_group_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FETCH_W    = FETCH_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic                        flush,
  output logic                        resp_valid,
  output logic [$clog2(FETCH_W):0]    resp_count,
  output logic [FETCH_W*DATA_W-1:0]   instr_flat,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_resp_valid,
  input  logic [DATA_W-1:0]           mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_W - OFF_BITS - IDX_BITS;
  localparam int CNT_BITS = $clog2(FETCH_W) + 1;
  localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

  state_t                       state;
  logic [ADDR_W-1:0]            addr_q;
  logic [NUM_LINES-1:0]         valid;
  logic [TAG_BITS-1:0]          tags [NUM_LINES];
  logic [OFF_BITS-1:0]          req_cnt;
  logic [OFF_BITS-1:0]          beat_cnt;
  logic                         fill_flushed;
  logic                         resp_wait;
  logic [LINE_WORDS*DATA_W-1:0] rd_line;
  logic [FETCH_W*DATA_W-1:0]    grp_flat;
  logic [CNT_BITS-1:0]          grp_cnt;

  logic [OFF_BITS-1:0] off_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [TAG_BITS-1:0] tag_q;
  logic                hit;
  logic                beat;
  logic                last_beat;

  assign off_q     = addr_q[OFF_BITS-1:0];
  assign idx_q     = addr_q[OFF_BITS +: IDX_BITS];
  assign tag_q     = addr_q[ADDR_W-1 -: TAG_BITS];
  // A flush seen during lookup forces a miss.
  assign hit       = valid[idx_q] && (tags[idx_q] == tag_q) && !flush;
  assign beat      = (state == FILL) && mem_resp_valid;
  assign last_beat = beat && (beat_cnt == LAST_WORD);

  icache_data_array #(
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .OFF_BITS  (OFF_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_data (
    .clk    (clk),
    .we     (beat),
    .wr_idx (idx_q),
    .wr_off (beat_cnt),
    .wr_data(mem_resp_data),
    .rd_idx (idx_q),
    .rd_line(rd_line)
  );

  always_comb begin
    grp_flat = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      if (int'(off_q) + l < LINE_WORDS)
        grp_flat[(FETCH_W-1-l)*DATA_W +: DATA_W] = rd_line[(int'(off_q)+l)*DATA_W +: DATA_W];
    end
    grp_cnt = CNT_BITS'(group_lanes(FETCH_W, LINE_WORDS, int'(off_q)));
  end

  always_ff @(posedge clk) begin
    if (last_beat) tags[idx_q] <= tag_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      valid         <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_count    <= '0;
      instr_flat    <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      req_cnt       <= '0;
      beat_cnt      <= '0;
      fill_flushed  <= 1'b0;
      resp_wait     <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
      hit_count     <= '0;
      miss_count    <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            state     <= LOOKUP;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state     <= RESP;
            resp_wait <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
`endif
          end else begin
            state         <= FILL;
            mem_req_valid <= 1'b1;
            mem_addr      <= {addr_q[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
            req_cnt       <= '0;
            beat_cnt      <= '0;
            fill_flushed  <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
`endif
          end
        end
        FILL: begin
          if (mem_req_valid && mem_req_ready) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            req_cnt  <= req_cnt + OFF_BITS'(1);
            if (req_cnt == LAST_WORD) mem_req_valid <= 1'b0;
          end
          if (beat) beat_cnt <= beat_cnt + OFF_BITS'(1);
          if (last_beat) begin
            state     <= RESP;
            resp_wait <= 1'b1;
            if (!fill_flushed) valid[idx_q] <= 1'b1;
          end
          if (flush) fill_flushed <= 1'b1;
        end
        RESP: begin
          // After a fill the last word lands on the same edge as the read; wait one cycle.
          if (resp_wait) begin
            resp_wait <= 1'b0;
          end else begin
            resp_valid <= 1'b1;
            resp_count <= grp_cnt;
            instr_flat <= grp_flat;
            state      <= IDLE;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush) valid <= '0;
    end
  end

endmodule

// File: tb/tb_icache_fetch_group.sv
// Directed self-checking bench for icache_fetch_group; backing memory returns 0x1000 + word address.
module tb_icache_fetch_group;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic [2:0]  resp_count;
  logic [63:0] instr_flat;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [14:0] mem_addr;
  logic        mem_resp_valid;
  logic [15:0] mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_fetch_group dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_count    (resp_count),
    .instr_flat    (instr_flat),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    lat = 0;
  string step = "init";
  bit    ready_mode = 1'b0;
  logic [14:0] q[$];
  logic [14:0] req_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
    end
  endtask

  // Backing memory: handshakes seen at a negedge complete on the following posedge.
  initial begin
    logic        hs;
    logic        rbeat;
    logic [14:0] hs_addr;
    hs = 1'b0; rbeat = 1'b0; hs_addr = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(negedge clk);
      if (rbeat) void'(q.pop_front());
      if (hs) begin
        q.push_back(hs_addr);
        req_log.push_back(hs_addr);
      end
      mem_resp_valid = (q.size() > 0);
      mem_resp_data  = (q.size() > 0) ? 16'h1000 + {1'b0, q[0]} : 16'h0;
      rbeat = mem_resp_valid;
      mem_req_ready = ready_mode ? ~mem_req_ready : 1'b1;
      hs = mem_req_valid && mem_req_ready;
      hs_addr = mem_addr;
    end
  end

  task automatic start_req(input logic [14:0] addr);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("resp_valid", resp_valid, 1);
    lat = cyc - acc_cyc;
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);
  endtask

  task automatic check_group(input logic [2:0] ecnt, input logic [63:0] eflat, input int ereqs,
                             input logic [14:0] addr);
    logic [14:0] base;
    base = {addr[14:3], 3'b000};
    check("count", resp_count, ecnt);
    check("flat", instr_flat, eflat);
    check("nreq", req_log.size(), ereqs);
    for (int i = 0; i < req_log.size(); i++) check("mem_addr", req_log[i], base + 15'(i));
  endtask

  task automatic fetch(input logic [14:0] addr, input logic [2:0] ecnt, input logic [63:0] eflat,
                       input int ereqs);
    req_log.delete();
    start_req(addr);
    wait_resp();
    check_group(ecnt, eflat, ereqs, addr);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;

    step = "reset";
    repeat (3) @(negedge clk);
    check("req_ready", req_ready, 0);
    check("resp_valid", resp_valid, 0);
    check("resp_count", resp_count, 0);
    check("instr_flat", instr_flat, 0);
    check("mem_req_valid", mem_req_valid, 0);
    check("mem_addr", mem_addr, 0);
    rst_n = 1'b1;

    step = "cold_miss";
    fetch(15'h0010, 3'd4, 64'h1010_1011_1012_1013, 8);

    step = "hit";
    fetch(15'h0012, 3'd4, 64'h1012_1013_1014_1015, 0);
    check("latency", lat, 2);

    step = "truncate";
    fetch(15'h0016, 3'd2, 64'h1016_1017_0000_0000, 0);

    step = "conflict";
    fetch(15'h0210, 3'd4, 64'h1210_1211_1212_1213, 8);
    fetch(15'h0010, 3'd4, 64'h1010_1011_1012_1013, 8);

    step = "flush_fill";
    req_log.delete();
    start_req(15'h0020);
    n = 0;
    while (req_log.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_resp();
    check_group(3'd4, 64'h1020_1021_1022_1023, 8, 15'h0020);
    step = "after_flush";
    fetch(15'h0020, 3'd4, 64'h1020_1021_1022_1023, 8);
    fetch(15'h0012, 3'd4, 64'h1012_1013_1014_1015, 8);

    step = "backpressure";
    ready_mode = 1'b1;
    fetch(15'h0043, 3'd4, 64'h1043_1044_1045_1046, 8);
    ready_mode = 1'b0;

    step = "rst_mid_fill";
    req_log.delete();
    start_req(15'h0050);
    n = 0;
    while (req_log.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_fill_active", mem_req_valid, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("req_ready", req_ready, 0);
    check("resp_valid", resp_valid, 0);
    check("resp_count", resp_count, 0);
    check("instr_flat", instr_flat, 0);
    check("mem_req_valid", mem_req_valid, 0);
    check("mem_addr", mem_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    step = "after_reset";
    fetch(15'h0050, 3'd4, 64'h1050_1051_1052_1053, 8);
    fetch(15'h0055, 3'd3, 64'h1055_1056_1057_0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
